pipe_elastic_chain: RTL and testbench
=====================================

Name: pipe_elastic_chain

Overview:
- Parametrised, elastic pipeline-register chain replacing the hand-written per-boundary pipereg modules (fetch/decode, decode/execute, etc.).
- Each of STAGES slots holds a DATA_W payload plus a valid bit, using valid/ready flow control with backward ready chaining.
- Adds global stall, partial flush (kill the youngest slots, keep the oldest) and saturating stall/flush performance counters.
- Sits between any two CPU stages or is chained to build multi-cycle execute paths.

Parameters:
- DATA_W, 32, payload width in bits.
- STAGES, 4, number of register slots (>=1). Slot 0 is nearest the input; slot STAGES-1 drives the output.
- CNT_W, 16, width of each performance counter.
- OCC_W, $clog2(STAGES+1), width of occupancy_o and flush_keep_i.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  chain can accept a payload this cycle.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  slot STAGES-1 holds a deliverable payload.
- out_ready_i  input  1  downstream accepts the payload.
- out_data_o  output  DATA_W  payload in slot STAGES-1.
- stall_i  input  1  freeze the whole chain.
- flush_i  input  1  kill the youngest slots.
- flush_keep_i  input  OCC_W  number of oldest slots that survive a flush.
- occupancy_o  output  OCC_W  count of valid slots.
- stall_cnt_o  output  CNT_W  cycles with stall_i=1 (saturating).
- flush_cnt_o  output  CNT_W  cycles with flush_i=1 (saturating).

Behaviour:
- Reset (synchronous, reset_i=1 at a rising clk_i edge):
  - All valid bits, data registers, occupancy_o and both counters go to 0.
  - Reset overrides flush_i, stall_i and any transfer in the same cycle.
  - Reset mid-stream discards all in-flight payloads.
- Outputs during and after reset: out_valid_o=0, in_ready_o=1 (unless stall_i or flush_i), out_data_o=0.
- Slot ready: rdy[k] = !v[k] | rdy[k+1], with rdy[STAGES] = out_ready_i.
  - This is a purely combinational backward path.
  - in_ready_o = rdy[0] & !stall_i & !flush_i.
- Output qualification: out_valid_o = v[STAGES-1] & !stall_i & !flush_i. out_data_o always shows slot STAGES-1.
  - Valid may drop without a transfer. This is intentional, CPU-internal, and not AXI-compliant.
- Normal cycle (stall_i=0, flush_i=0):
  - Slot k loads slot k-1 (slot 0 loads input) when rdy[k]=1.
  - v[k] takes the source's valid; if rdy[k]=0, slot k holds.
  - Input transfer occurs on in_valid_i & in_ready_o; output transfer on out_valid_o & out_ready_i.
  - Latency: exactly STAGES cycles from input acceptance to out_valid_o, when the chain is empty and never back-pressured.
  - Throughput: one payload per cycle.
- Bubbles: empty slots collapse. A younger payload advances into an empty slot even while the output is blocked.
- Stall (stall_i=1, flush_i=0):
  - No slot or valid changes; no input or output transfer.
  - stall_cnt_o increments by 1.
- Flush (flush_i=1, overrides stall):
  - No shift, no input or output transfer.
  - Every slot k < STAGES - flush_keep_i has v[k] cleared. Data registers are left unchanged.
  - flush_keep_i=0 clears all slots; flush_keep_i >= STAGES clears none.
  - flush_cnt_o increments by 1. stall_cnt_o also increments if stall_i=1.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- occupancy_o: registered, equals popcount(v) after each edge. Range is 0..STAGES.
- Boundary cases:
  - Full chain with out_ready_i=0: in_ready_o=0.
  - Full chain with out_ready_i=1: simultaneous in and out transfer; occupancy stays STAGES.
  - STAGES=1: chain behaves as a single full-throughput register.

Test Plan:
- Reset, then drive in_data 0x11,0x22,0x33,0x44,0x55 on consecutive cycles with out_ready_i=1, STAGES=4 -> 0x11 appears with out_valid_o=1 exactly 4 cycles after acceptance; the values follow back-to-back; occupancy peaks at 4.
- Hold out_ready_i=0 while driving 6 inputs -> 4 accepted, in_ready_o=0 after the 4th; raising out_ready_i releases 0x11..0x44 in order with no loss or duplication.
- With a full chain, assert stall_i for 3 cycles with in_valid_i=1 and out_ready_i=1 -> no transfers, out_valid_o=0, state unchanged, stall_cnt_o=3.
- With a full chain (slots 0..3 = D,C,B,A), apply flush_i=1 with flush_keep_i=1 -> only A survives, occupancy_o=1; the next out transfer delivers A; a later flush with keep=0 yields occupancy_o=0; flush_cnt_o=2.
- Assert flush_i and stall_i together with in_valid_i=1 -> input not accepted; flush_cnt_o and stall_cnt_o both +1.
- Pulse reset_i mid-stream with occupancy 3 -> next cycle all outputs and counters are 0; subsequently force CNT_W=4 and hold stall_i 20 cycles -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/pipe_elastic_chain.sv
// ---------------------------------------------------------------------------
// pipe_elastic_chain
//
// Parametrised elastic pipeline-register chain. STAGES slots each hold a
// DATA_W payload and a valid bit. Flow control is valid/ready with a
// combinational backward ready chain, so bubbles collapse and the chain
// sustains one payload per cycle. A global stall freezes everything. A
// partial flush kills the youngest slots and keeps the oldest flush_keep_i.
// Saturating counters record stall and flush cycles.
//
// Slot 0 is nearest the input. Slot STAGES-1 drives the output.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset
//   in_valid_i    upstream payload valid
//   in_ready_o    chain accepts a payload this cycle
//   in_data_i     upstream payload
//   out_valid_o   slot STAGES-1 holds a deliverable payload
//   out_ready_i   downstream accepts the payload
//   out_data_o    payload in slot STAGES-1 (always shown)
//   stall_i       freeze the whole chain
//   flush_i       kill the youngest slots (overrides stall)
//   flush_keep_i  number of oldest slots that survive a flush
//   occupancy_o   registered count of valid slots
//   stall_cnt_o   saturating count of cycles with stall_i=1
//   flush_cnt_o   saturating count of cycles with flush_i=1
// ---------------------------------------------------------------------------
module pipe_elastic_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [OCC_W-1:0]  flush_keep_i,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [STAGES-1:0] v_q, v_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Backward ready chain: a slot can load when it is empty or when the slot
  // after it is loading too. The running value is carried in a local so the
  // rdy vector never depends on itself.
  always_comb begin : ready_chain
    logic r;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    r   = out_ready_i;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = ~v_q[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready_o  = rdy[0] & ~stall_i & ~flush_i;
  // Valid may drop under stall/flush without a transfer having happened.
  assign out_valid_o = v_q[STAGES-1] & ~stall_i & ~flush_i;
  assign out_data_o  = data_q[STAGES-1];
  assign occupancy_o = occ_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Slot next-state: flush clears valids only, stall holds, otherwise each
  // ready slot loads from its source (input for slot 0).
  always_comb begin : slot_next
    v_d    = v_q;
    data_d = data_q;
    if (flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        if ((32'(k) + 32'(flush_keep_i)) < 32'(STAGES)) begin
          v_d[k] = 1'b0;
        end
      end
    end else if (!stall_i) begin
      if (rdy[0]) begin
        v_d[0]    = in_valid_i;
        data_d[0] = in_data_i;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_d[k]    = v_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  // Occupancy is registered: popcount of the next valid vector.
  always_comb begin : occ_next
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin : cnt_next
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q         <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      // NOTE: payload registers are reset too, because out_data_o must read
      // zero after reset; this costs a reset net on every data flop.
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_elastic_chain
//
// Directed bench for pipe_elastic_chain (STAGES=4, DATA_W=32). A table of
// per-cycle vectors holds the inputs applied in a cycle and the outputs
// expected during that cycle. Hand-written sequences cover mid-stream reset
// and counter saturation, the latter on a second instance with CNT_W=4.
// ---------------------------------------------------------------------------
module tb_pipe_elastic_chain;

  localparam int DATA_W = 32;
  localparam int STAGES = 4;
  localparam int OCC_W  = 3;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              stall_i;
  logic              flush_i;
  logic [OCC_W-1:0]  flush_keep_i;
  logic [OCC_W-1:0]  occupancy_o;
  logic [15:0]       stall_cnt_o;
  logic [15:0]       flush_cnt_o;

  logic              s_in_ready_o;
  logic              s_out_valid_o;
  logic [DATA_W-1:0] s_out_data_o;
  logic [OCC_W-1:0]  s_occupancy_o;
  logic [3:0]        s_stall_cnt_o;
  logic [3:0]        s_flush_cnt_o;

  pipe_elastic_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .stall_i(stall_i), .flush_i(flush_i), .flush_keep_i(flush_keep_i),
    .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Same stimulus, narrow counters, for the saturation check.
  pipe_elastic_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(4)) u_dut_small (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(s_out_valid_o), .out_ready_i(out_ready_i), .out_data_o(s_out_data_o),
    .stall_i(stall_i), .flush_i(flush_i), .flush_keep_i(flush_keep_i),
    .occupancy_o(s_occupancy_o), .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        st;
    logic        fl;
    logic [2:0]  keep;
    logic        ov;
    logic        ir;
    logic        cd;   // compare out_data this cycle
    logic [31:0] od;
    logic [2:0]  occ;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic ordy,
                     input logic st, input logic fl, input logic [2:0] keep,
                     input logic ov, input logic ir, input logic cd,
                     input logic [31:0] od, input logic [2:0] occ,
                     input logic [15:0] sc, input logic [15:0] fc);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.st = st; v.fl = fl; v.keep = keep;
    v.ov = ov; v.ir = ir; v.cd = cd; v.od = od; v.occ = occ; v.sc = sc; v.fc = fc;
    tbl.push_back(v);
  endtask

  // Inputs are applied just after a rising edge, outputs checked on the
  // falling edge, then the rising edge commits the cycle.
  task automatic run_vec(input vec_t v, input int idx);
    in_valid_i   = v.iv;
    in_data_i    = v.id;
    out_ready_i  = v.ordy;
    stall_i      = v.st;
    flush_i      = v.fl;
    flush_keep_i = v.keep;
    @(negedge clk_i);
    check($sformatf("v%0d.out_valid", idx), 32'(out_valid_o), 32'(v.ov));
    check($sformatf("v%0d.in_ready", idx), 32'(in_ready_o), 32'(v.ir));
    check($sformatf("v%0d.occupancy", idx), 32'(occupancy_o), 32'(v.occ));
    check($sformatf("v%0d.stall_cnt", idx), 32'(stall_cnt_o), 32'(v.sc));
    check($sformatf("v%0d.flush_cnt", idx), 32'(flush_cnt_o), 32'(v.fc));
    if (v.cd) check($sformatf("v%0d.out_data", idx), out_data_o, v.od);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //   iv id        rdy st fl kp  ov ir cd od        occ sc fc
    // Streaming, out_ready=1: 0x11 shows 4 cycles after acceptance.
    add(1, 32'h11, 1, 0, 0, 0,  0, 1, 1, 32'h00, 0, 0, 0);
    add(1, 32'h22, 1, 0, 0, 0,  0, 1, 1, 32'h00, 1, 0, 0);
    add(1, 32'h33, 1, 0, 0, 0,  0, 1, 0, 32'h00, 2, 0, 0);
    add(1, 32'h44, 1, 0, 0, 0,  0, 1, 0, 32'h00, 3, 0, 0);
    add(1, 32'h55, 1, 0, 0, 0,  1, 1, 1, 32'h11, 4, 0, 0);
    add(0, 32'h55, 1, 0, 0, 0,  1, 1, 1, 32'h22, 4, 0, 0);
    add(0, 32'h55, 1, 0, 0, 0,  1, 1, 1, 32'h33, 3, 0, 0);
    add(0, 32'h55, 1, 0, 0, 0,  1, 1, 1, 32'h44, 2, 0, 0);
    add(0, 32'h55, 1, 0, 0, 0,  1, 1, 1, 32'h55, 1, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  0, 1, 0, 32'h00, 0, 0, 0);
    // Back-pressure: six offered, four accepted, then drained in order.
    add(1, 32'h11, 0, 0, 0, 0,  0, 1, 0, 32'h00, 0, 0, 0);
    add(1, 32'h22, 0, 0, 0, 0,  0, 1, 0, 32'h00, 1, 0, 0);
    add(1, 32'h33, 0, 0, 0, 0,  0, 1, 0, 32'h00, 2, 0, 0);
    add(1, 32'h44, 0, 0, 0, 0,  0, 1, 0, 32'h00, 3, 0, 0);
    add(1, 32'h55, 0, 0, 0, 0,  1, 0, 1, 32'h11, 4, 0, 0);
    add(1, 32'h66, 0, 0, 0, 0,  1, 0, 1, 32'h11, 4, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  1, 1, 1, 32'h11, 4, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  1, 1, 1, 32'h22, 3, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  1, 1, 1, 32'h33, 2, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  1, 1, 1, 32'h44, 1, 0, 0);
    add(0, 32'h00, 1, 0, 0, 0,  0, 1, 0, 32'h00, 0, 0, 0);
    // Fill with A1 (oldest) .. D4, then stall three cycles.
    add(1, 32'hA1, 0, 0, 0, 0,  0, 1, 0, 32'h00, 0, 0, 0);
    add(1, 32'hB2, 0, 0, 0, 0,  0, 1, 0, 32'h00, 1, 0, 0);
    add(1, 32'hC3, 0, 0, 0, 0,  0, 1, 0, 32'h00, 2, 0, 0);
    add(1, 32'hD4, 0, 0, 0, 0,  0, 1, 0, 32'h00, 3, 0, 0);
    add(1, 32'hEE, 1, 1, 0, 0,  0, 0, 1, 32'hA1, 4, 0, 0);
    add(1, 32'hEE, 1, 1, 0, 0,  0, 0, 1, 32'hA1, 4, 1, 0);
    add(1, 32'hEE, 1, 1, 0, 0,  0, 0, 1, 32'hA1, 4, 2, 0);
    // Flush keep=1: only A1 survives and is delivered next.
    add(1, 32'hEE, 1, 0, 1, 1,  0, 0, 1, 32'hA1, 4, 3, 0);
    add(1, 32'hE5, 1, 0, 0, 0,  1, 1, 1, 32'hA1, 1, 3, 1);
    // E5 advances into empty slots while the output is blocked.
    add(0, 32'h00, 0, 0, 0, 0,  0, 1, 0, 32'h00, 1, 3, 1);
    // Flush keep=0 clears everything.
    add(0, 32'h00, 0, 0, 1, 0,  0, 0, 0, 32'h00, 1, 3, 1);
    add(0, 32'h00, 1, 0, 0, 0,  0, 1, 0, 32'h00, 0, 3, 2);
    // Flush and stall together: input refused, both counters step.
    add(1, 32'h77, 1, 1, 1, 0,  0, 0, 0, 32'h00, 0, 3, 2);
    add(0, 32'h00, 1, 0, 0, 0,  0, 1, 0, 32'h00, 0, 4, 3);

    reset_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; flush_keep_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst.out_valid", 32'(out_valid_o), 32'd0);
    check("rst.in_ready", 32'(in_ready_o), 32'd1);
    check("rst.out_data", out_data_o, 32'd0);
    check("rst.occupancy", 32'(occupancy_o), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst.flush_cnt", 32'(flush_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Mid-stream reset with three payloads in flight; reset wins over
    // simultaneous stall, flush and input.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'h100 + 32'(i);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid.occupancy", 32'(occupancy_o), 32'd3);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1; in_valid_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0; in_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("mrst.out_valid", 32'(out_valid_o), 32'd0);
    check("mrst.in_ready", 32'(in_ready_o), 32'd1);
    check("mrst.out_data", out_data_o, 32'd0);
    check("mrst.occupancy", 32'(occupancy_o), 32'd0);
    check("mrst.stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("mrst.flush_cnt", 32'(flush_cnt_o), 32'd0);
    check("mrst.small_stall_cnt", 32'(s_stall_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;

    // 20 stall cycles: the 4-bit counter sticks at 15, the 16-bit one reads 20.
    stall_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    stall_i = 1'b0;
    @(negedge clk_i);
    check("sat.small_stall_cnt", 32'(s_stall_cnt_o), 32'd15);
    check("sat.small_flush_cnt", 32'(s_flush_cnt_o), 32'd0);
    check("sat.stall_cnt", 32'(stall_cnt_o), 32'd20);
    check("sat.occupancy", 32'(occupancy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
